// File: rtl/core_seq_pkg.sv
// Shared constants and types for the core_seq_dec fetch/decode sequencer.
// Covers the OP-IMM encodings, the sequencer states and the op-strobe bundle.
package core_seq_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } state_e;

    // First member lands in the MSB: addi is bit 8, srai is bit 0.
    typedef struct packed {
        logic addi;
        logic slti;
        logic sltiu;
        logic xori;
        logic ori;
        logic andi;
        logic slli;
        logic srli;
        logic srai;
    } op_strobes_t;

endpackage

// File: rtl/core_seq_dec_if.sv
// Instruction-memory request/ready port between core_seq_dec and its fetch memory.
interface core_seq_dec_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/core_seq_dec_op_imm_decode.sv
// Combinational OP-IMM decoder: one-hot op strobes plus an illegal flag.
module op_imm_decode
    import core_seq_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_strobes_t strobes_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr_i[6:0];
    assign funct3        = instr_i[14:12];
    assign funct7        = instr_i[31:25];
    assign unused_fields = ^instr_i[24:15] ^ ^instr_i[11:7];

    always_comb begin
        strobes_o = '0;
        illegal_o = 1'b1;
        if (opcode == OPC_OP_IMM) begin
            illegal_o = 1'b0;
            unique case (funct3)
                F3_ADDI:  strobes_o.addi  = 1'b1;
                F3_SLTI:  strobes_o.slti  = 1'b1;
                F3_SLTIU: strobes_o.sltiu = 1'b1;
                F3_XORI:  strobes_o.xori  = 1'b1;
                F3_ORI:   strobes_o.ori   = 1'b1;
                F3_ANDI:  strobes_o.andi  = 1'b1;
                F3_SLLI: begin
                    if (funct7 == F7_ZERO) strobes_o.slli = 1'b1;
                    else                   illegal_o      = 1'b1;
                end
                F3_SRXI: begin
                    if (funct7 == F7_ZERO)     strobes_o.srli = 1'b1;
                    else if (funct7 == F7_SRA) strobes_o.srai = 1'b1;
                    else                       illegal_o      = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/core_seq_dec.sv
// Fetch/decode sequencer: fetches one OP-IMM word, runs EXEC_CYCLES execute cycles, advances pc.
// Optional CORE_SEQ_ILLEGAL_HALT_EN: an illegal word parks the core in HALT instead of skipping.
module core_seq_dec
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic           hclk,
    input  logic           hrstn,
    input  logic           core_en,
    core_seq_dec_if.master imem,
    output logic [31:0]    pc,
    output logic [3:0]     cycle_cnt,
    output logic           dec_branch_en,
    output logic           dec_addi,
    output logic           dec_slti,
    output logic           dec_sltiu,
    output logic           dec_xori,
    output logic           dec_ori,
    output logic           dec_andi,
    output logic           dec_slli,
    output logic           dec_srli,
    output logic           dec_srai,
    output logic [11:0]    dec_imm_type_i,
    output logic [4:0]     dec_rd,
    output logic [4:0]     dec_rs1,
    output logic           dec_illegal,
    output logic           instr_retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_next;
    logic [3:0]  cnt_q, cnt_d;
    op_strobes_t ops_q, ops_d, dec_ops;
    logic        dec_bad;
    logic [11:0] imm_q, imm_d;
    logic [4:0]  rd_q, rd_d, rs1_q, rs1_d;
    logic        illegal_q, illegal_d;
    logic        retired_q, retired_d;

    // Decode the word on the bus so the strobes are registered on the accepting edge.
    op_imm_decode u_decode (
        .instr_i   (imem.imem_rdata),
        .strobes_o (dec_ops),
        .illegal_o (dec_bad)
    );

    assign pc_next = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ops_d     = ops_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        illegal_d = 1'b0;
        retired_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (core_en) state_d = StFetch;
            end
            StFetch: begin
                if (imem.imem_ready) begin
                    imm_d = imem.imem_rdata[31:20];
                    rd_d  = imem.imem_rdata[11:7];
                    rs1_d = imem.imem_rdata[19:15];
                    if (dec_bad) begin
                        illegal_d = 1'b1;
`ifdef CORE_SEQ_ILLEGAL_HALT_EN
                        state_d   = StHalt;
`else
                        pc_d      = pc_next;
                        state_d   = core_en ? StFetch : StIdle;
`endif
                    end else begin
                        ops_d   = dec_ops;
                        cnt_d   = 4'd1;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (cnt_q == 4'(EXEC_CYCLES)) begin
                    cnt_d     = 4'd0;
                    ops_d     = '0;
                    pc_d      = pc_next;
                    retired_d = 1'b1;
                    state_d   = core_en ? StFetch : StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            cnt_q     <= 4'd0;
            ops_q     <= '0;
            imm_q     <= 12'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            illegal_q <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ops_q     <= ops_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign imem.imem_req  = (state_q == StFetch);
    assign imem.imem_addr = pc_q;

    assign pc             = pc_q;
    assign cycle_cnt      = cnt_q;
    assign dec_branch_en  = (state_q == StExec);
    assign {dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori, dec_andi,
            dec_slli, dec_srli, dec_srai} = ops_q;
    assign dec_imm_type_i = imm_q;
    assign dec_rd         = rd_q;
    assign dec_rs1        = rs1_q;
    assign dec_illegal    = illegal_q;
    assign instr_retired  = retired_q;

endmodule
